icache: RTL
===========

# icache

Direct-mapped instruction cache answering the instruction fetcher's word-fetch requests and refilling lines from the memory controller. It sits between the fetcher (fetch-address side) and the memory controller (word-read side). Hits return combinationally in the same cycle, so the fetcher can consume one instruction per cycle. Misses run a multi-word line refill.

## Interface
- `LINES`, 64: number of lines; power of two, ≥2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥2.
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global enable; when low, all state holds.
- `fetch_addr` in 32: byte address requested by the fetcher; bits [1:0] ignored.
- `instr_out_valid` out 1: `instr_out` holds the word at `fetch_addr` this cycle.
- `instr_out` out 32: instruction word.
- `mem_req` out 1: word read request, held until `mem_done`.
- `mem_addr` out 32: word-aligned read address.
- `mem_done` in 1: one-cycle pulse; `mem_data` valid.
- `mem_data` in 32: returned word.

## Operation
- Address split:
  - offset = `[log2(LINE_WORDS)+1:2]`;
  - index = next `log2(LINES)` bits;
  - tag = remaining upper bits.
- Storage per line: valid bit, tag, `LINE_WORDS` data words.
- Hit = `valid[index] && tag[index]==tag(fetch_addr)`. On a hit, `instr_out_valid=1` and `instr_out=data[index][offset]`, purely combinational.
- States: IDLE, FILL.
- IDLE:
  - Miss with `rdy` → latch line base (`fetch_addr` with offset and byte bits zeroed) and index.
  - Clear `valid[index]`, reset word counter to 0, go to FILL.
- FILL:
  - `mem_req=1`, `mem_addr=base+4*cnt`.
  - On `mem_done`: write `mem_data` into `data[idx][cnt]` and increment `cnt`.
  - On `mem_done` with `cnt==LINE_WORDS-1`: write tag, set valid, deassert `mem_req` next cycle, return to IDLE.
- During FILL, hits to other lines are still served. The line being filled reports a miss.
- `fetch_addr` may change at any time (fetcher redirect or flush). An in-progress fill always completes; it is never aborted.
- A miss to a different line during FILL is not latched. It is detected again in IDLE.
- Counter arithmetic is `log2(LINE_WORDS)` bits and wraps to 0 after the last word.

## Timing
- Reset values: state IDLE, all valid bits 0, `mem_req=0`, `mem_addr=0`, `cnt=0`. `instr_out_valid` is 0 because no line is valid.
- Reset mid-fill: the fill is dropped, `mem_req` is low the next cycle, and the partial line stays invalid.
- Hit latency: 0 cycles.
- Miss penalty:
  - Miss seen in cycle T; `mem_req` high from T+1.
  - The line becomes valid after the final `mem_done` edge.
  - The hit is visible in the cycle after the final `mem_done` (without early restart).
- `mem_req`/`mem_addr` are registered and stable until `mem_done`. The next word's request is presented the cycle after `mem_done`.
- `rdy` low: no state, counter, or array update, and any `mem_done` in that cycle is ignored. The memory controller is gated by the same `rdy`.
- Simultaneous final `mem_done` and a new miss on another line: finish the fill; the new miss is taken in the following IDLE cycle.

## Configuration
- `ICACHE_EARLY_RESTART_EN` defined:
  - In FILL, when `mem_done` is high and `fetch_addr` matches the word being returned, assert `instr_out_valid` with `instr_out=mem_data` in that same cycle.
  - The fill continues normally.
- Undefined: words are served only from the array after the line is valid.

## Structure
- Shared package/header holds:
  - FSM state encodings (IDLE, FILL);
  - the `ADDR_WIDTH=32` constant;
  - the index/offset/tag width helper constants derived from `LINES`/`LINE_WORDS`.
- One sub-module, `icache_data_array`:
  - `LINES*LINE_WORDS` × 32 storage;
  - combinational read port (index, offset);
  - synchronous single-word write port.
- The top holds valid and tag arrays, the FSM, and hit logic.

## Test plan
- Reset, then `fetch_addr=0x0` → `instr_out_valid=0`, `mem_req=1`, `mem_addr=0x0` next cycle. After 4 `mem_done` (data 0x11,0x22,0x33,0x44), `fetch_addr=0x8` → `instr_out=0x33`, valid in the same cycle.
- Sequential fetch `0x0,0x4,0x8,0xC` after refill → valid every cycle with no `mem_req`. Then `0x10` → miss with `mem_addr` sequence `0x10,0x14,0x18,0x1C`.
- Conflict (LINES=64, LINE_WORDS=4): fill `0x0`, then fetch `0x400` (same index, different tag) → miss and refill. Fetching `0x0` again → miss.
- Redirect mid-fill: miss on `0x20`, after 2 `mem_done` change `fetch_addr` to a valid cached line → hit served immediately. The fill of `0x20` still completes and `0x20` then hits.
- Assert `rst` after 2 `mem_done` → `mem_req=0` next cycle, all valid bits cleared; `0x0` and `0x20` then miss.
- With `ICACHE_EARLY_RESTART_EN`: miss on `0x28` (offset 2) → `instr_out_valid=1` exactly in the third `mem_done` cycle with `instr_out=mem_data`. Without the macro, valid first appears after the fourth `mem_done`.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the direct-mapped instruction cache.
// Optional early restart is enabled by defining ICACHE_EARLY_RESTART_EN.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    localparam int ADDR_WIDTH = 32;
    localparam int BYTE_BITS  = 2;

    function automatic int offset_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int index_width(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tag_width(input int lines, input int line_words);
        return ADDR_WIDTH - BYTE_BITS - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetcher-side and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport is its environment.
interface icache_if;
    import icache_pkg::*;

    logic                  rdy;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  instr_out_valid;
    logic [31:0]           instr_out;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_done;
    logic [31:0]           mem_data;

    modport slave (
        input  rdy, fetch_addr, mem_done, mem_data,
        output instr_out_valid, instr_out, mem_req, mem_addr
    );

    modport master (
        output rdy, fetch_addr, mem_done, mem_data,
        input  instr_out_valid, instr_out, mem_req, mem_addr
    );

endinterface

// File: rtl/icache_data_array.sv
// Instruction word storage: combinational read by (index, offset),
// synchronous single-word write during refill.
module icache_data_array #(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [$clog2(LINES)-1:0]      wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_offset,
    input  logic [31:0]                   wr_data,
    input  logic [$clog2(LINES)-1:0]      rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_offset,
    output logic [31:0]                   rd_data
);

    logic [31:0] words [LINES*LINE_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            words[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_data = words[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache top: valid/tag arrays, hit logic and refill FSM.
// Define ICACHE_EARLY_RESTART_EN to forward the returning refill word to the fetcher.
module icache
    import icache_pkg::*;
#(
    parameter int LINES      = 64,
    parameter int LINE_WORDS = 4
) (
    input logic     clk,
    input logic     rst,
    icache_if.slave bus
);

    localparam int OFF_W   = offset_width(LINE_WORDS);
    localparam int IDX_W   = index_width(LINES);
    localparam int TAG_W   = tag_width(LINES, LINE_WORDS);
    localparam int IDX_LSB = BYTE_BITS + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    logic [OFF_W-1:0] fetch_off;
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             unused_byte_bits;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic [OFF_W-1:0] cnt;

    logic             hit;
    logic             word_done;
    logic [31:0]      rd_data;

    assign fetch_off        = bus.fetch_addr[IDX_LSB-1:BYTE_BITS];
    assign fetch_idx        = bus.fetch_addr[TAG_LSB-1:IDX_LSB];
    assign fetch_tag        = bus.fetch_addr[ADDR_WIDTH-1:TAG_LSB];
    assign unused_byte_bits = ^bus.fetch_addr[BYTE_BITS-1:0];

    // The line under refill had its valid bit cleared on entry, so it always misses here.
    assign hit       = valid[fetch_idx] && (tags[fetch_idx] == fetch_tag);
    assign word_done = (state == FILL) && bus.rdy && bus.mem_done;

    icache_data_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS)
    ) u_data_array (
        .clk       (clk),
        .wr_en     (word_done && !rst),
        .wr_index  (fill_idx),
        .wr_offset (cnt),
        .wr_data   (bus.mem_data),
        .rd_index  (fetch_idx),
        .rd_offset (fetch_off),
        .rd_data   (rd_data)
    );

`ifdef ICACHE_EARLY_RESTART_EN
    logic early_hit;

    assign early_hit = word_done &&
                       (bus.fetch_addr[ADDR_WIDTH-1:BYTE_BITS] == bus.mem_addr[ADDR_WIDTH-1:BYTE_BITS]);
    assign bus.instr_out_valid = hit || early_hit;
    assign bus.instr_out       = hit ? rd_data : bus.mem_data;
`else
    assign bus.instr_out_valid = hit;
    assign bus.instr_out       = rd_data;
`endif

    // A refill, once started, always runs to the last word; redirects only change what hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            valid        <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            cnt          <= '0;
            fill_idx     <= '0;
            fill_tag     <= '0;
        end else if (bus.rdy) begin
            unique case (state)
                IDLE: begin
                    if (!hit) begin
                        fill_idx           <= fetch_idx;
                        fill_tag           <= fetch_tag;
                        valid[fetch_idx]   <= 1'b0;
                        cnt                <= '0;
                        bus.mem_req        <= 1'b1;
                        bus.mem_addr       <= {bus.fetch_addr[ADDR_WIDTH-1:IDX_LSB], {IDX_LSB{1'b0}}};
                        state              <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_done) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_WORD) begin
                            tags[fill_idx]  <= fill_tag;
                            valid[fill_idx] <= 1'b1;
                            bus.mem_req     <= 1'b0;
                            bus.mem_addr    <= {fill_tag, fill_idx, {IDX_LSB{1'b0}}};
                            state           <= IDLE;
                        end else begin
                            bus.mem_addr <= bus.mem_addr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
